// File: rtl/lc_req_queue.sv
// lc_req_queue: in-order request buffer between the L1D lower-cache port and
// the next-level cache. It absorbs line reads and 64-byte write-backs while the
// lower cache stalls. Fill responses do not pass through this block.
//
// Optional feature macro: LC_REQ_COALESCE_EN.
//   When it is defined, a write-back to the same line as the newest queued
//   write merges into that entry in place.
//   When it is undefined (the default), every push allocates a new entry.
//
// Ports
//   clk_in        clock; all state changes on posedge
//   rst_N_in      synchronous active-low reset
//   l1_valid_in   L1D request valid
//   l1_ready_out  queue can accept (not full and out of reset)
//   l1_addr_in    line address (stored line aligned)
//   l1_value_in   write-back data (stored as 0 for reads)
//   l1_we_in      1 = write-back, 0 = line read
//   lc_valid_out  head entry valid (queue not empty)
//   lc_ready_in   lower cache accepts head
//   lc_addr_out   head line address, 0 when empty
//   lc_value_out  head data, 0 when empty
//   lc_we_out     head write flag, 0 when empty
//   count_out     occupancy 0..DEPTH
module lc_req_queue #(
    parameter int unsigned PADDR_BITS = 22,
    parameter int unsigned LINE_BITS  = 512,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_N_in,
    input  logic                     l1_valid_in,
    output logic                     l1_ready_out,
    input  logic [PADDR_BITS-1:0]    l1_addr_in,
    input  logic [LINE_BITS-1:0]     l1_value_in,
    input  logic                     l1_we_in,
    output logic                     lc_valid_out,
    input  logic                     lc_ready_in,
    output logic [PADDR_BITS-1:0]    lc_addr_out,
    output logic [LINE_BITS-1:0]     lc_value_out,
    output logic                     lc_we_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PADDR_BITS-1:0] LINE_MASK = ~PADDR_BITS'(63);

    // Pointers carry one extra bit so a full queue is distinguishable from an empty one.
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic                   rst_done_q;

    // Payload storage; deliberately not reset, empty outputs are gated instead.
    logic [PADDR_BITS-1:0]  mem_addr  [DEPTH];
    logic [LINE_BITS-1:0]   mem_value [DEPTH];
    logic [DEPTH-1:0]       mem_we;

    logic [PW-1:0]          occ;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   coalesce;
    logic                   alloc;
    logic [AW-1:0]          wr_idx;
    logic [AW-1:0]          rd_idx;
    logic [PADDR_BITS-1:0]  push_addr;
    logic [LINE_BITS-1:0]   push_value;

`ifdef LC_REQ_COALESCE_EN
    logic [PW-1:0]          tail_ptr;
    logic [AW-1:0]          tail_idx;
`endif

    // Occupancy, handshake and entry-select decode.
    always_comb begin
        occ        = wr_ptr - rd_ptr;
        full       = (occ == PW'(DEPTH));
        empty      = (occ == '0);
        push       = rst_N_in && l1_valid_in && l1_ready_out;
        pop        = rst_N_in && !empty && lc_ready_in;
        wr_idx     = wr_ptr[AW-1:0];
        rd_idx     = rd_ptr[AW-1:0];
        push_addr  = l1_addr_in & LINE_MASK;
        push_value = l1_we_in ? l1_value_in : '0;
        coalesce   = 1'b0;
`ifdef LC_REQ_COALESCE_EN
        tail_ptr   = wr_ptr - PW'(1);
        tail_idx   = tail_ptr[AW-1:0];
        // Merge only into a newest-entry write that is not leaving the queue this cycle.
        coalesce   = push && l1_we_in && !empty && mem_we[tail_idx] &&
                     (mem_addr[tail_idx] == push_addr) &&
                     !(pop && (occ == PW'(1)));
`endif
        alloc      = push && !coalesce;
    end

    // Pointer and reset-state registers.
    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            if (alloc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Entry storage writes: allocate at the tail, or merge into the newest write.
    always_ff @(posedge clk_in) begin
        if (alloc) begin
            mem_addr[wr_idx]  <= push_addr;
            mem_value[wr_idx] <= push_value;
            mem_we[wr_idx]    <= l1_we_in;
        end
`ifdef LC_REQ_COALESCE_EN
        if (coalesce) begin
            mem_value[tail_idx] <= l1_value_in;
        end
`endif
    end

    // Outputs derive from registered state only; head fields are forced to 0 when empty.
    assign l1_ready_out = rst_done_q && !full;
    assign lc_valid_out = !empty;
    assign lc_addr_out  = empty ? '0 : mem_addr[rd_idx];
    assign lc_value_out = empty ? '0 : mem_value[rd_idx];
    assign lc_we_out    = !empty && mem_we[rd_idx];
    assign count_out    = occ;

endmodule

// File: tb/tb_lc_req_queue.sv
// Bench for lc_req_queue: directed cases with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_lc_req_queue;

    localparam int unsigned PA    = 22;
    localparam int unsigned LB    = 512;
    localparam int unsigned DEPTH = 4;

    logic            clk_in = 1'b0;
    logic            rst_N_in;
    logic            l1_valid_in;
    logic            l1_ready_out;
    logic [PA-1:0]   l1_addr_in;
    logic [LB-1:0]   l1_value_in;
    logic            l1_we_in;
    logic            lc_valid_out;
    logic            lc_ready_in;
    logic [PA-1:0]   lc_addr_out;
    logic [LB-1:0]   lc_value_out;
    logic            lc_we_out;
    logic [2:0]      count_out;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    lc_req_queue #(.PADDR_BITS(PA), .LINE_BITS(LB), .DEPTH(DEPTH)) dut (
        .clk_in       (clk_in),
        .rst_N_in     (rst_N_in),
        .l1_valid_in  (l1_valid_in),
        .l1_ready_out (l1_ready_out),
        .l1_addr_in   (l1_addr_in),
        .l1_value_in  (l1_value_in),
        .l1_we_in     (l1_we_in),
        .lc_valid_out (lc_valid_out),
        .lc_ready_in  (lc_ready_in),
        .lc_addr_out  (lc_addr_out),
        .lc_value_out (lc_value_out),
        .lc_we_out    (lc_we_out),
        .count_out    (count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of requests in arrival order.
    typedef struct {
        logic [PA-1:0] addr;
        logic [LB-1:0] value;
        logic          we;
    } ent_t;

    ent_t q[$];
    bit   mdl_rdy = 1'b0;

    always @(posedge clk_in) begin
        if (!rst_N_in) begin
            q.delete();
            mdl_rdy = 1'b0;
        end else begin
            bit   do_push;
            bit   do_pop;
            bit   merged;
            ent_t e;
            do_push = l1_valid_in && mdl_rdy && (q.size() < DEPTH);
            do_pop  = (q.size() > 0) && lc_ready_in;
            merged  = 1'b0;
            e.addr  = l1_addr_in & ~PA'(63);
            e.value = l1_we_in ? l1_value_in : '0;
            e.we    = l1_we_in;
`ifdef LC_REQ_COALESCE_EN
            if (do_push && l1_we_in && q.size() > 0 && q[q.size()-1].we &&
                q[q.size()-1].addr == e.addr && !(do_pop && q.size() == 1)) begin
                q[q.size()-1].value = l1_value_in;
                merged = 1'b1;
            end
`endif
            if (do_pop) void'(q.pop_front());
            if (do_push && !merged) q.push_back(e);
            mdl_rdy = 1'b1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("ready", 512'(l1_ready_out), 512'(mdl_rdy && q.size() < DEPTH));
            chk("count", 512'(count_out), 512'(q.size()));
            chk("valid", 512'(lc_valid_out), 512'(q.size() > 0));
            if (q.size() > 0) begin
                chk("head_addr", 512'(lc_addr_out), 512'(q[0].addr));
                chk("head_value", lc_value_out, q[0].value);
                chk("head_we", 512'(lc_we_out), 512'(q[0].we));
            end else begin
                chk("idle_addr", 512'(lc_addr_out), '0);
                chk("idle_value", lc_value_out, '0);
                chk("idle_we", 512'(lc_we_out), '0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PA-1:0] a, input logic w, input logic [LB-1:0] d);
        l1_valid_in = v;
        l1_addr_in  = a;
        l1_we_in    = w;
        l1_value_in = d;
    endtask

    initial begin
        logic [PA-1:0] pop_seq [5];
        logic [LB-1:0] val_a;
        logic [LB-1:0] val_b;
        logic [LB-1:0] rv;

        rst_N_in    = 1'b0;
        lc_ready_in = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        val_a = 512'hAAAA_0001;
        val_b = 512'hBBBB_0002;

        // Reset held for two cycles.
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_ready", 512'(l1_ready_out), 512'(0));
        chk("rst_valid", 512'(lc_valid_out), 512'(0));
        chk("rst_count", 512'(count_out), 512'(0));
        chk("rst_addr", 512'(lc_addr_out), 512'(0));
        rst_N_in = 1'b1;
        cyc();
        chk("rel_ready", 512'(l1_ready_out), 512'(1));

        // Single read, one-cycle latency, then popped.
        lc_ready_in = 1'b1;
        drive(1'b1, 22'h060300, 1'b0, '1);
        cyc();
        drive(1'b0, '0, 1'b0, '0);
        chk("rd_valid", 512'(lc_valid_out), 512'(1));
        chk("rd_addr", 512'(lc_addr_out), 512'(22'h060300));
        chk("rd_we", 512'(lc_we_out), 512'(0));
        chk("rd_value", lc_value_out, '0);
        cyc();
        chk("rd_count0", 512'(count_out), 512'(0));

        // Fill to full while the lower cache stalls.
        lc_ready_in = 1'b0;
        drive(1'b1, 22'h005000, 1'b0, '0); cyc();
        drive(1'b1, 22'h007004, 1'b0, '0); cyc();
        drive(1'b1, 22'h009004, 1'b0, '0); cyc();
        drive(1'b1, 22'h00F004, 1'b0, '0); cyc();
        chk("full_count", 512'(count_out), 512'(4));
        chk("full_ready", 512'(l1_ready_out), 512'(0));
        chk("full_head", 512'(lc_addr_out), 512'(22'h005000));

        // Full with pop and push offered together: push waits one cycle.
        drive(1'b1, 22'h001234, 1'b0, '0);
        lc_ready_in = 1'b1;
        pop_seq[0] = 22'h007000;
        pop_seq[1] = 22'h009000;
        pop_seq[2] = 22'h00F000;
        pop_seq[3] = 22'h001200;
        cyc();
        chk("fs_count", 512'(count_out), 512'(3));
        chk("fs_head", 512'(lc_addr_out), 512'(pop_seq[0]));
        cyc();
        drive(1'b0, '0, 1'b0, '0);
        chk("fs_count2", 512'(count_out), 512'(3));
        for (int i = 1; i < 4; i++) begin
            chk("drain_head", 512'(lc_addr_out), 512'(pop_seq[i]));
            cyc();
        end
        chk("drain_empty", 512'(lc_valid_out), 512'(0));

        // Write-back address alignment and data.
        lc_ready_in = 1'b0;
        drive(1'b1, 22'h004050, 1'b1, 512'hC0C0C0C0);
        cyc();
        drive(1'b0, '0, 1'b0, '0);
        chk("wb_we", 512'(lc_we_out), 512'(1));
        chk("wb_addr", 512'(lc_addr_out), 512'(22'h004040));
        chk("wb_value", lc_value_out, 512'hC0C0C0C0);
        lc_ready_in = 1'b1;
        cyc();

        // Back-to-back writes to one line.
        lc_ready_in = 1'b0;
        drive(1'b1, 22'h002000, 1'b1, val_a); cyc();
        drive(1'b1, 22'h002000, 1'b1, val_b); cyc();
        drive(1'b0, '0, 1'b0, '0);
`ifdef LC_REQ_COALESCE_EN
        chk("coal_count", 512'(count_out), 512'(1));
        chk("coal_head", lc_value_out, val_b);
`else
        chk("coal_count", 512'(count_out), 512'(2));
        chk("coal_head", lc_value_out, val_a);
`endif
        lc_ready_in = 1'b1;
        cyc(); cyc(); cyc();
        lc_ready_in = 1'b0;

        // An intervening read blocks any merge.
        drive(1'b1, 22'h002000, 1'b1, val_a); cyc();
        drive(1'b1, 22'h002000, 1'b0, '0);    cyc();
        drive(1'b1, 22'h002000, 1'b1, val_b); cyc();
        drive(1'b0, '0, 1'b0, '0);
        chk("wrw_count", 512'(count_out), 512'(3));

        // Reset mid-traffic discards everything.
        rst_N_in = 1'b0;
        cyc();
        chk("mid_rst_count", 512'(count_out), 512'(0));
        chk("mid_rst_valid", 512'(lc_valid_out), 512'(0));
        rst_N_in = 1'b1;
        cyc();
        chk("post_rst_valid", 512'(lc_valid_out), 512'(0));
        chk("post_rst_ready", 512'(l1_ready_out), 512'(1));

        // Randomized traffic; a few lines reused so merges and wrap both occur.
        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < 16; k++) rv[k*32 +: 32] = $urandom;
            rst_N_in    = ($urandom_range(0, 249) != 0);
            lc_ready_in = $urandom_range(0, 1) != 0;
            drive($urandom_range(0, 2) != 0,
                  PA'(($urandom_range(0, 3) << 6) | $urandom_range(0, 63)),
                  $urandom_range(0, 1) != 0, rv);
            cyc();
        end
        rst_N_in    = 1'b1;
        lc_ready_in = 1'b1;
        drive(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 6; i++) cyc();
        chk("final_empty", 512'(count_out), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
